// File: rtl/iobus_uart_tx_pkg.sv
// Shared constants and state encoding for the IOBUS UART transmitter.
package iobus_uart_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_MSB = 7;

  localparam int unsigned CTRL_IE  = 0;
  localparam int unsigned CTRL_CLR = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/iobus_uart_tx_if.sv
// CPU IOBUS responder signals; the CPU side is master, the UART is slave.
interface iobus_uart_tx_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input RD_DATA);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/iobus_uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push and pop may share an edge.
module iobus_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_push_ok
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign o_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (o_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({o_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU IOBUS with a TX FIFO and drain interrupt.
module iobus_uart_tx
  import iobus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0040,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  iobus_uart_tx_if.slave   bus,
  output logic             TX,
  output logic             IRQ
);

  localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  logic [31:0]     w_ofs;
  logic            w_hit_data, w_hit_status, w_hit_ctrl;
  logic            w_push_req, w_push_ok, w_ctrl_wr, w_clr;
  logic [7:0]      w_fifo_rdata;
  logic            w_full, w_empty;
  logic [CW-1:0]   w_count;
  logic            w_unused_ok;

  tx_state_t       r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic            w_wrap, w_pop, w_stop_done;

  logic            r_ie, r_pend, r_ovf;
  logic [31:0]     w_rd;

  assign w_ofs        = bus.IOBUS_ADDR - BASE_ADDR;
  assign w_hit_data   = (w_ofs == DATA_OFS);
  assign w_hit_status = (w_ofs == STATUS_OFS);
  assign w_hit_ctrl   = (w_ofs == CTRL_OFS);
  assign w_push_req   = bus.IOBUS_WR & w_hit_data;
  assign w_ctrl_wr    = bus.IOBUS_WR & w_hit_ctrl;
  assign w_clr        = w_ctrl_wr & bus.IOBUS_OUT[CTRL_CLR];
  assign w_unused_ok  = &{1'b0, bus.IOBUS_OUT[31:8]};

  iobus_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_push   (w_push_req),
    .i_wdata  (bus.IOBUS_OUT[7:0]),
    .i_pop    (w_pop),
    .o_rdata  (w_fifo_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count),
    .o_push_ok(w_push_ok)
  );

  assign w_wrap = (r_cnt == CNTW'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_stop_done = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_rdata;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_stop_done = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // TX is registered from the next state so the line level is glitch-free yet
    // changes on the same edge the state does.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ie   <= 1'b0;
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= bus.IOBUS_OUT[CTRL_IE];
      if (w_clr)
        r_ovf <= 1'b0;
      else if (w_push_req && !w_push_ok)
        r_ovf <= 1'b1;
      // Clearing wins over a drain completing on the same edge.
      if (w_clr || w_push_ok)
        r_pend <= 1'b0;
      else if (w_stop_done && w_empty)
        r_pend <= 1'b1;
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_hit_status) begin
      w_rd[STAT_BUSY]                 = (r_state != IDLE);
      w_rd[STAT_FULL]                 = w_full;
      w_rd[STAT_EMPTY]                = w_empty;
      w_rd[STAT_OVF]                  = r_ovf;
      w_rd[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(w_count);
    end else if (w_hit_ctrl) begin
      w_rd[CTRL_IE] = r_ie;
    end
  end

  assign bus.RD_DATA = w_rd;
  assign TX          = r_tx;
  assign IRQ         = r_pend & r_ie;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed self-checking bench for iobus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_iobus_uart_tx;

  localparam logic [31:0] B      = 32'h1100_0040;
  localparam logic [31:0] A_DATA = B;
  localparam logic [31:0] A_STAT = B + 32'h4;
  localparam logic [31:0] A_CTRL = B + 32'h8;

  logic clk, rst, tx, irq;
  int   n_total, n_bad;

  iobus_uart_tx_if bus ();

  iobus_uart_tx #(
    .BASE_ADDR   (B),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus),
    .TX (tx),
    .IRQ(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] bseq [6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    @(posedge clk);
    #1;
    bus.IOBUS_WR   = 1'b0;
  endtask

  // pos 0..39 within a frame at 4 clocks per bit
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos < 4) return 1'b0;
    if (pos >= 36) return 1'b1;
    return b[(pos - 4) / 4];
  endfunction

  // Five back-to-back frames, each followed by one idle cycle
  function automatic logic burst_tx(input int k);
    int f, pos;
    f   = k / 41;
    pos = k % 41;
    if (f >= 5 || pos == 40) return 1'b1;
    return frame_bit(bseq[f], pos);
  endfunction

  initial begin
    n_total = 0;
    n_bad   = 0;
    vecs[0]  = '{1'b0, 32'h0, 32'h0, A_STAT, 32'h4};
    vecs[1]  = '{1'b0, 32'h0, 32'h0, A_DATA, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 32'h0, A_CTRL, 32'h0};
    vecs[3]  = '{1'b1, A_CTRL, 32'h1, A_CTRL, 32'h1};
    vecs[4]  = '{1'b0, 32'h0, 32'h0, B + 32'hC, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 32'h1100_0000, 32'h0};
    vecs[6]  = '{1'b1, B + 32'hC, 32'hFFFF_FFFF, A_CTRL, 32'h1};
    vecs[7]  = '{1'b1, 32'h1100_0000, 32'hFF, A_STAT, 32'h4};
    vecs[8]  = '{1'b1, A_STAT, 32'hFF, A_STAT, 32'h4};
    vecs[9]  = '{1'b1, A_CTRL, 32'h3, A_CTRL, 32'h1};
    vecs[10] = '{1'b1, A_CTRL, 32'h2, A_CTRL, 32'h0};
    bseq[0] = 8'h11; bseq[1] = 8'h22; bseq[2] = 8'h33;
    bseq[3] = 8'h44; bseq[4] = 8'h55; bseq[5] = 8'h66;

    rst = 1'b1;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    bus.IOBUS_ADDR = A_STAT;
    #1;
    chk("reset_status", bus.RD_DATA, 32'h4);
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].waddr, vecs[i].wdata);
      bus.IOBUS_ADDR = vecs[i].raddr;
      #1;
      chk($sformatf("reg_vec%0d_rd", i), bus.RD_DATA, vecs[i].exp_rd);
      chk($sformatf("reg_vec%0d_tx", i), 32'(tx), 32'h1);
      chk($sformatf("reg_vec%0d_irq", i), 32'(irq), 32'h0);
    end

    // Single frame 0xA5: start on the second edge after the store
    bus_wr(A_DATA, 32'hA5);
    bus.IOBUS_ADDR = A_STAT;
    #1;
    chk("a5_edge1_tx", 32'(tx), 32'h1);
    chk("a5_edge1_status", bus.RD_DATA, 32'h10);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("a5_tx k=%0d", k), 32'(tx), 32'(frame_bit(8'hA5, k)));
      chk($sformatf("a5_busy k=%0d", k), 32'(bus.RD_DATA[0]), 32'h1);
    end
    step();
    chk("a5_end_tx", 32'(tx), 32'h1);
    chk("a5_end_status", bus.RD_DATA, 32'h4);
    chk("a5_end_irq_ie0", 32'(irq), 32'h0);

    // Interrupt: pending from the previous drain shows once IE is set
    bus_wr(A_CTRL, 32'h1);
    chk("ie_set_irq", 32'(irq), 32'h1);
    bus_wr(A_DATA, 32'h55);
    chk("push_clears_irq", 32'(irq), 32'h0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("x55_irq k=%0d", k), 32'(irq), 32'h0);
    end
    step();
    chk("x55_drain_irq", 32'(irq), 32'h1);
    bus_wr(A_CTRL, 32'h3);
    chk("ctrl_clr_irq", 32'(irq), 32'h0);
    bus.IOBUS_ADDR = A_CTRL;
    #1;
    chk("ctrl_clr_ie_kept", bus.RD_DATA, 32'h1);

    // Six back-to-back stores: one popped, four queued, one dropped
    bus_wr(A_DATA, 32'(bseq[0]));
    for (int i = 1; i < 6; i++) begin
      bus_wr(A_DATA, 32'(bseq[i]));
      chk($sformatf("burst_tx k=%0d", i - 1), 32'(tx), 32'(burst_tx(i - 1)));
    end
    bus.IOBUS_ADDR = A_STAT;
    #1;
    chk("burst_status_full", bus.RD_DATA, 32'h4B);
    for (int k = 5; k <= 230; k++) begin
      step();
      chk($sformatf("burst_tx k=%0d", k), 32'(tx), 32'(burst_tx(k)));
      chk($sformatf("burst_irq k=%0d", k), 32'(irq), 32'(k >= 204));
    end
    chk("burst_status_drained", bus.RD_DATA, 32'h0C);
    bus_wr(A_CTRL, 32'h3);
    bus.IOBUS_ADDR = A_STAT;
    #1;
    chk("ovf_cleared_status", bus.RD_DATA, 32'h4);
    chk("ovf_cleared_irq", 32'(irq), 32'h0);

    // Reset in the middle of data bit 3
    bus_wr(A_DATA, 32'hA5);
    bus.IOBUS_ADDR = A_STAT;
    for (int k = 0; k <= 17; k++) step();
    chk("rst_pre_tx_bit3", 32'(tx), 32'h0);
    chk("rst_pre_busy", 32'(bus.RD_DATA[0]), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_status", bus.RD_DATA, 32'h4);
    chk("rst_irq", 32'(irq), 32'h0);
    bus.IOBUS_ADDR = A_CTRL;
    #1;
    chk("rst_ctrl", bus.RD_DATA, 32'h0);
    bus.IOBUS_ADDR = A_STAT;
    for (int k = 0; k < 60; k++) begin
      step();
      chk($sformatf("rst_idle_tx k=%0d", k), 32'(tx), 32'h1);
    end
    chk("rst_final_status", bus.RD_DATA, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the CPU IOBUS as a responder.
- Receives CPU stores (IOBUS_ADDR, IOBUS_OUT, IOBUS_WR) and buffers bytes in a small FIFO.
- Serialises the bytes 8N1 on TX.
- Returns status on a read-data port that the top level ORs into the CPU IOBUS input.
- Raises a level interrupt, routed to the CPU interrupt input, when transmission drains.

Parameters:
- BASE_ADDR, 32'h1100_0040, base of the 3-word register window.
- CLKS_PER_BIT, 434, clocks per serial bit (50 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2, <= 8.

Ports:
- CLK  in  1  system clock. All logic is on the rising edge.
- RST  in  1  reset. Synchronous, active-high.
- IOBUS_ADDR  in  32  CPU load/store address.
- IOBUS_OUT  in  32  CPU store data.
- IOBUS_WR  in  1  CPU store strobe, one cycle per store.
- RD_DATA  out  32  read data for the addressed register. 0 when the address is outside the window.
- TX  out  1  serial line, idle high.
- IRQ  out  1  level interrupt request.

Behaviour:
- Register map, word aligned, byte offsets from BASE_ADDR:
  - 0x0 DATA (write-only, reads 0). A store pushes IOBUS_OUT[7:0].
  - 0x4 STATUS (read-only):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] count
    - remaining bits 0
  - 0x8 CTRL:
    - bit0 IE (read/write)
    - bit1 write-1 clears IRQ pending and overflow; reads 0
  - Any other address: writes ignored, RD_DATA = 0.
- RD_DATA is purely combinational from IOBUS_ADDR and registered state. There is no read strobe and reads have no side effects.
- Reset values: TX=1, IRQ=0, IE=0, pending=0, overflow=0, FIFO empty, FSM IDLE, baud counter 0, RD_DATA follows the reset state.
- Push: a DATA store writes the FIFO on that clock edge.
  - If full and no pop on the same edge, the byte is dropped and overflow is set.
  - If full with a pop on the same edge, the push is accepted and count is unchanged.
- FSM states: IDLE, START, DATA, STOP. Each of START, DATA-bit and STOP lasts exactly CLKS_PER_BIT cycles, timed by a counter 0..CLKS_PER_BIT-1.
  - IDLE: TX=1. When the FIFO is not empty, pop the head into the shift register, go to START, clear the counter.
  - START: TX=0. On counter wrap, go to DATA with bit index 0.
  - DATA: TX = shift[0], LSB first. On wrap, shift right and increment the index. After index 7, go to STOP.
  - STOP: TX=1. On wrap, go to IDLE.
- A byte pushed into an empty FIFO while IDLE drives TX low on the 2nd edge after the store: edge 1 pushes, edge 2 pops and enters START.
- A frame is 10*CLKS_PER_BIT cycles. If the FIFO is not empty when STOP ends, IDLE lasts exactly 1 cycle before the next START.
- IRQ pending sets on the edge where STOP completes with the FIFO empty and no push on that edge.
  - IRQ = pending & IE.
  - Pending clears on a CTRL write with bit1=1, or on any accepted DATA push.
  - If set and clear occur on the same edge, clear wins.
- RST mid-frame aborts the frame immediately: TX=1 on the next cycle and all state returns to reset values.

Decomposition:
- Package iobus_uart_pkg holds:
  - register offset constants DATA_OFS, STATUS_OFS, CTRL_OFS
  - the status bit index constants
  - the typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}
- One sub-module, iobus_sync_fifo:
  - parameterised DEPTH and WIDTH=8
  - push, pop, full, empty, count
  - same-edge push+pop allowed
- The top level holds the address decode, CTRL/IRQ logic, baud counter and FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then read STATUS -> RD_DATA = 32'h0000_0004; TX=1; IRQ=0.
- Store 0xA5 to DATA while idle -> TX low from edge 2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high for 4 cycles. STATUS busy=1 throughout the frame.
- Set IE=1, store 0x55, wait for frame end -> IRQ=1 on the cycle after STOP ends. A CTRL write of 0x3 drops IRQ the next cycle and IE stays 1.
- Store 6 bytes back-to-back while IDLE -> first byte popped. Bytes 2-5 fill the FIFO and byte 6 is dropped: STATUS count=4, full=1, overflow=1. Exactly 5 frames are emitted, with 1 idle cycle between frames.
- Read address BASE_ADDR+0xC and address 0x1100_0000 -> RD_DATA = 0. Writes to those addresses leave all STATUS/CTRL values unchanged.
- Assert RST during DATA bit 3 -> TX=1 the next cycle, STATUS=0x4, IRQ=0, and no further frame is emitted.
